// File: rtl/ripple_carry_adder_10_pkg.sv
// ---------------------------------------------------------------------------
// ripple_carry_adder_10_pkg
// Shared constants and types for the 10-bit ripple-carry adder and any
// datapath block (e.g. the ALU) that consumes its operands and results.
//
// Contents:
//   RCA_W       - operand / sum width (10)
//   rca_word_t  - operand / sum word type
//   rca_res_t   - carry-out plus sum, as produced by the adder
// ---------------------------------------------------------------------------
package ripple_carry_adder_10_pkg;

    localparam int RCA_W = 10;

    typedef logic [RCA_W-1:0] rca_word_t;

    typedef struct packed {
        logic      cout;
        rca_word_t sum;
    } rca_res_t;

endpackage : ripple_carry_adder_10_pkg

// File: rtl/full_adder_1.sv
// ---------------------------------------------------------------------------
// full_adder_1
// One-bit full adder cell used as a stage of the ripple-carry chain.
//
// Ports:
//   i_a, i_b  - operand bits
//   i_c       - carry in from the previous stage (or cin for stage 0)
//   o_s       - sum bit
//   o_co      - carry out to the next stage
// ---------------------------------------------------------------------------
module full_adder_1 (
    input  logic i_a,
    input  logic i_b,
    input  logic i_c,
    output logic o_s,
    output logic o_co
);

    assign o_s  = i_a ^ i_b ^ i_c;
    assign o_co = (i_a & i_b) | (i_a & i_c) | (i_b & i_c);

endmodule : full_adder_1

// File: rtl/ripple_carry_adder_10.sv
// ---------------------------------------------------------------------------
// ripple_carry_adder_10
// Registered 10-bit ripple-carry adder: {cout,sum} = A + B + cin, one cycle
// of latency, one result per cycle. Subtraction is done by the caller
// presenting ~B with cin=1.
//
// Optional feature: define RCA10_OVERFLOW_EN to add the registered signed
// overflow output. Without it the port and its logic do not exist.
//
// Ports:
//   clk        - rising-edge clock
//   reset      - synchronous, active-high; clears all outputs
//   A, B       - operands (unsigned or two's complement)
//   cin        - carry into bit 0
//   in_valid   - A/B/cin are qualified this cycle
//   sum        - registered low WIDTH bits of A+B+cin
//   cout       - registered carry out of the top bit
//   out_valid  - sum/cout hold a result from in_valid one cycle earlier
//   overflow   - (RCA10_OVERFLOW_EN) registered signed overflow
// ---------------------------------------------------------------------------
module ripple_carry_adder_10
    import ripple_carry_adder_10_pkg::*;
#(
    parameter int WIDTH = RCA_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             cin,
    input  logic             in_valid,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             out_valid
`ifdef RCA10_OVERFLOW_EN
    ,
    output logic             overflow
`endif
);

    // w_carry[i] is the carry into stage i; w_carry[WIDTH] is the final carry out.
    logic [WIDTH:0]   w_carry;
    logic [WIDTH-1:0] w_sum;

    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic             r_vld_p0;

    assign w_carry[0] = cin;

    // Combinational carry chain: stage i feeds stage i+1
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_stage
        full_adder_1 u_fa (
            .i_a  (A[gi]),
            .i_b  (B[gi]),
            .i_c  (w_carry[gi]),
            .o_s  (w_sum[gi]),
            .o_co (w_carry[gi+1])
        );
    end

    // Output register stage: result held while in_valid is low
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sum    <= '0;
            r_cout   <= 1'b0;
            r_vld_p0 <= 1'b0;
        end else begin
            r_vld_p0 <= in_valid;
            if (in_valid) begin
                r_sum  <= w_sum;
                r_cout <= w_carry[WIDTH];
            end
        end
    end

    assign sum       = r_sum;
    assign cout      = r_cout;
    assign out_valid = r_vld_p0;

`ifdef RCA10_OVERFLOW_EN
    logic w_ovf;
    logic r_ovf;

    // Signed overflow: carry into the sign bit disagrees with carry out of it
    assign w_ovf = w_carry[WIDTH-1] ^ w_carry[WIDTH];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ovf <= 1'b0;
        end else if (in_valid) begin
            r_ovf <= w_ovf;
        end
    end

    assign overflow = r_ovf;
`endif

endmodule : ripple_carry_adder_10

// File: tb/tb_ripple_carry_adder_10.sv
// ---------------------------------------------------------------------------
// tb_ripple_carry_adder_10
// Scoreboard bench for ripple_carry_adder_10. Expected results are computed
// with integer arithmetic when stimulus is driven, queued, and popped when
// the registered result is due. Idle cycles check that outputs hold.
// ---------------------------------------------------------------------------
module tb_ripple_carry_adder_10;

    logic       clk = 1'b0;
    logic       reset;
    logic [9:0] A;
    logic [9:0] B;
    logic       cin;
    logic       in_valid;
    logic [9:0] sum;
    logic       cout;
    logic       out_valid;
`ifdef RCA10_OVERFLOW_EN
    logic       overflow;
`endif

    ripple_carry_adder_10 #(.WIDTH(10)) dut (
        .clk       (clk),
        .reset     (reset),
        .A         (A),
        .B         (B),
        .cin       (cin),
        .in_valid  (in_valid),
        .sum       (sum),
        .cout      (cout),
        .out_valid (out_valid)
`ifdef RCA10_OVERFLOW_EN
        ,
        .overflow  (overflow)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [9:0] sum;
        logic       cout;
        logic       ovf;
    } exp_t;

    exp_t       sb_q[$];
    int         n_checks = 0;
    int         n_errors = 0;
    logic [9:0] hold_sum;
    logic       hold_cout;
    logic       hold_ovf;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [9:0] a, input logic [9:0] b, input logic c);
        exp_t e;
        int   t;
        t      = int'(a) + int'(b) + int'(c);
        e.sum  = t[9:0];
        e.cout = t[10];
        // Same-sign operands producing a result of the other sign
        e.ovf  = (a[9] == b[9]) && (e.sum[9] != a[9]);
        return e;
    endfunction

    // Drive one cycle of stimulus, then check the registered outputs after the edge.
    task automatic step(input string tag, input logic [9:0] a, input logic [9:0] b,
                        input logic c, input logic vld, input logic rst);
        exp_t e;
        reset    = rst;
        A        = a;
        B        = b;
        cin      = c;
        in_valid = vld;
        if (vld && !rst) sb_q.push_back(model(a, b, c));
        @(posedge clk);
        #1;
        if (rst) begin
            sb_q.delete();
            chk({tag, ".rst_vld"},  32'(out_valid), 32'd0);
            chk({tag, ".rst_sum"},  32'(sum),       32'd0);
            chk({tag, ".rst_cout"}, 32'(cout),      32'd0);
`ifdef RCA10_OVERFLOW_EN
            chk({tag, ".rst_ovf"},  32'(overflow),  32'd0);
`endif
            hold_sum  = '0;
            hold_cout = 1'b0;
            hold_ovf  = 1'b0;
        end else if (vld) begin
            chk({tag, ".vld"}, 32'(out_valid), 32'd1);
            if (sb_q.size() == 0) begin
                chk({tag, ".sb_empty"}, 32'd1, 32'd0);
            end else begin
                e = sb_q.pop_front();
                chk({tag, ".sum"},  32'(sum),  32'(e.sum));
                chk({tag, ".cout"}, 32'(cout), 32'(e.cout));
`ifdef RCA10_OVERFLOW_EN
                chk({tag, ".ovf"},  32'(overflow), 32'(e.ovf));
`endif
                hold_sum  = e.sum;
                hold_cout = e.cout;
                hold_ovf  = e.ovf;
            end
        end else begin
            chk({tag, ".idle_vld"},  32'(out_valid), 32'd0);
            chk({tag, ".hold_sum"},  32'(sum),       32'(hold_sum));
            chk({tag, ".hold_cout"}, 32'(cout),      32'(hold_cout));
`ifdef RCA10_OVERFLOW_EN
            chk({tag, ".hold_ovf"},  32'(overflow),  32'(hold_ovf));
`endif
        end
    endtask

    initial begin
        logic [9:0] ra;
        logic [9:0] rb;
        logic       rc;
        logic       rv;

        reset     = 1'b1;
        A         = '0;
        B         = '0;
        cin       = 1'b0;
        in_valid  = 1'b0;
        hold_sum  = '0;
        hold_cout = 1'b0;
        hold_ovf  = 1'b0;

        // Reset, including one cycle with a competing valid operation
        step("reset0", 10'd0,   10'd0, 1'b0, 1'b0, 1'b1);
        step("reset1", 10'd100, 10'd7, 1'b1, 1'b1, 1'b1);

        // Directed vectors, back to back
        step("add15_10",   10'd15,   10'd10,   1'b0, 1'b1, 1'b0);
        step("sub20_8",    10'd20,   10'd1015, 1'b1, 1'b1, 1'b0);
        step("sub5_10",    10'd5,    10'd1013, 1'b1, 1'b1, 1'b0);
        step("wrap_1023_1",10'd1023, 10'd1,    1'b0, 1'b1, 1'b0);
        step("max_all",    10'd1023, 10'd1023, 1'b1, 1'b1, 1'b0);
        step("ovf_511_1",  10'd511,  10'd1,    1'b0, 1'b1, 1'b0);
        step("ovf_512_512",10'd512,  10'd512,  1'b0, 1'b1, 1'b0);
        step("zero",       10'd0,    10'd0,    1'b0, 1'b1, 1'b0);
        step("cin_only",   10'd0,    10'd0,    1'b1, 1'b1, 1'b0);
        step("alt_bits",   10'h2AA,  10'h155,  1'b1, 1'b1, 1'b0);

        // Idle cycles with changing operands: outputs must hold
        step("idle0", 10'd3,   10'd4, 1'b1, 1'b0, 1'b0);
        step("idle1", 10'd999, 10'd9, 1'b0, 1'b0, 1'b0);

        // Reset mid-stream with a valid operation pending, then resume
        step("pre_rst", 10'd300, 10'd200, 1'b0, 1'b1, 1'b0);
        step("mid_rst", 10'd400, 10'd500, 1'b1, 1'b1, 1'b1);
        step("post_idle", 10'd1, 10'd2, 1'b0, 1'b0, 1'b0);
        step("resume",  10'd123, 10'd456, 1'b0, 1'b1, 1'b0);

        // Random sweep with random valid gaps
        for (int i = 0; i < 10000; i++) begin
            ra = 10'($urandom_range(0, 1023));
            rb = 10'($urandom_range(0, 1023));
            rc = 1'($urandom_range(0, 1));
            rv = ($urandom_range(0, 3) != 0);
            step("rand", ra, rb, rc, rv, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule : tb_ripple_carry_adder_10
